// File: rtl/mem_arbiter.sv
// Serialises the dual-issue FU0/FU1 memory pair onto one data-memory port and returns both results together.
// Optional store-to-load forwarding from slot 0 to slot 1 is built when MEM_ARB_FWD_EN is defined.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          in_valid,
    input  logic [1:0]          in_we,
    input  logic [ADDR_W-1:0]   in_addr0,
    input  logic [ADDR_W-1:0]   in_addr1,
    input  logic [DATA_W-1:0]   in_wdata0,
    input  logic [DATA_W-1:0]   in_wdata1,
    input  logic [DATA_W/8-1:0] in_be0,
    input  logic [DATA_W/8-1:0] in_be1,
    output logic                in_ready,
    output logic                stall,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                out_valid,
    output logic [1:0]          out_slot_valid,
    output logic [DATA_W-1:0]   out_rdata0,
    output logic [DATA_W-1:0]   out_rdata1
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, DONE} state_t;
    state_t state_reg, state_next;

    logic              accept;
    logic              fwd_sel;
    logic              slot_sel;
    logic              valid_buf_reg [2];
    logic              we_buf_reg    [2];
    logic [ADDR_W-1:0] addr_buf_reg  [2];
    logic [DATA_W-1:0] wdata_buf_reg [2];
    logic [BE_W-1:0]   be_buf_reg    [2];
    logic [ADDR_W-1:0] addr_in       [2];
    logic [DATA_W-1:0] wdata_in      [2];
    logic [BE_W-1:0]   be_in         [2];
    logic [DATA_W-1:0] res_reg       [2];
    logic [DATA_W-1:0] res_next      [2];
    logic [1:0]        out_slot_valid_reg;
    logic [DATA_W-1:0] out_rdata0_reg, out_rdata1_reg;

    assign accept      = (state_reg == IDLE) && (|in_valid);
    assign addr_in[0]  = in_addr0;
    assign addr_in[1]  = in_addr1;
    assign wdata_in[0] = in_wdata0;
    assign wdata_in[1] = in_wdata1;
    assign be_in[0]    = in_be0;
    assign be_in[1]    = in_be1;

    // Per-slot request buffers, loaded only when a pair is accepted.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_buf_reg[gi] <= 1'b0;
                    we_buf_reg[gi]    <= 1'b0;
                    addr_buf_reg[gi]  <= '0;
                    wdata_buf_reg[gi] <= '0;
                    be_buf_reg[gi]    <= '0;
                end else if (accept) begin
                    valid_buf_reg[gi] <= in_valid[gi];
                    we_buf_reg[gi]    <= in_we[gi];
                    addr_buf_reg[gi]  <= addr_in[gi];
                    wdata_buf_reg[gi] <= wdata_in[gi];
                    be_buf_reg[gi]    <= be_in[gi];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    res_reg[gi] <= '0;
                end else begin
                    res_reg[gi] <= res_next[gi];
                end
            end
        end
    endgenerate

`ifdef MEM_ARB_FWD_EN
    logic fwd_hit;
    logic fwd_sel_reg;

    // Full-word store followed by a load of the same word: slot 1 takes the store data.
    assign fwd_hit = (&in_valid) && in_we[0] && !in_we[1] &&
                     (in_addr0[ADDR_W-1:2] == in_addr1[ADDR_W-1:2]) && (&in_be0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_sel_reg <= 1'b0;
        end else if (accept) begin
            fwd_sel_reg <= fwd_hit;
        end
    end

    assign fwd_sel = fwd_sel_reg;
`else
    assign fwd_sel = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        res_next[0] = res_reg[0];
        res_next[1] = res_reg[1];
        case (state_reg)
            IDLE: begin
                if (|in_valid) begin
                    state_next  = in_valid[0] ? ISSUE0 : ISSUE1;
                    res_next[0] = '0;
                    res_next[1] = '0;
                end
            end
            ISSUE0: begin
                if (mem_req_ready) state_next = WAIT0;
            end
            WAIT0: begin
                if (mem_resp_valid) begin
                    if (!we_buf_reg[0]) res_next[0] = mem_rdata;
                    if (fwd_sel) begin
                        res_next[1] = wdata_buf_reg[0];
                        state_next  = DONE;
                    end else begin
                        state_next = valid_buf_reg[1] ? ISSUE1 : DONE;
                    end
                end
            end
            ISSUE1: begin
                if (mem_req_ready) state_next = WAIT1;
            end
            WAIT1: begin
                if (mem_resp_valid) begin
                    if (!we_buf_reg[1]) res_next[1] = mem_rdata;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Results become visible only on entry to DONE and then hold until the next pair completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_slot_valid_reg <= '0;
            out_rdata0_reg     <= '0;
            out_rdata1_reg     <= '0;
        end else if (state_next == DONE) begin
            out_slot_valid_reg <= {valid_buf_reg[1], valid_buf_reg[0]};
            out_rdata0_reg     <= res_next[0];
            out_rdata1_reg     <= res_next[1];
        end
    end

    assign slot_sel = (state_reg == ISSUE1);

    always_comb begin
        mem_req_valid = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_be        = '0;
        if ((state_reg == ISSUE0) || (state_reg == ISSUE1)) begin
            mem_req_valid = 1'b1;
            mem_we        = we_buf_reg[slot_sel];
            mem_addr      = addr_buf_reg[slot_sel];
            mem_wdata     = wdata_buf_reg[slot_sel];
            mem_be        = be_buf_reg[slot_sel];
        end
    end

    assign in_ready       = (state_reg == IDLE);
    assign stall          = ~in_ready;
    assign out_valid      = (state_reg == DONE);
    assign out_slot_valid = out_slot_valid_reg;
    assign out_rdata0     = out_rdata0_reg;
    assign out_rdata1     = out_rdata1_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus hand sequences, with request/result scoreboards.
module tb_mem_arbiter;
    logic        clk;
    logic        rst_n;
    logic [1:0]  in_valid, in_we;
    logic [31:0] in_addr0, in_addr1, in_wdata0, in_wdata1;
    logic [3:0]  in_be0, in_be1;
    logic        in_ready, stall;
    logic        mem_req_valid, mem_req_ready, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [1:0]  out_slot_valid;
    logic [31:0] out_rdata0, out_rdata1;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_we(in_we),
        .in_addr0(in_addr0), .in_addr1(in_addr1),
        .in_wdata0(in_wdata0), .in_wdata1(in_wdata1),
        .in_be0(in_be0), .in_be1(in_be1),
        .in_ready(in_ready), .stall(stall),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_slot_valid(out_slot_valid),
        .out_rdata0(out_rdata0), .out_rdata1(out_rdata1)
    );

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  we;
        logic [31:0] addr0, addr1, wdata0, wdata1;
        logic [3:0]  be0, be1;
        logic        skip1;
        logic [31:0] r0, r1;
        int          lat;
    } vec_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; } req_t;
    typedef struct { logic [1:0] sv; logic [31:0] r0; logic [31:0] r1; int lat; } res_t;

    req_t req_q[$];
    res_t res_q[$];
    vec_t vecs[8];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    int   outv_cnt = 0;
    int   resp_delay = 0;
    logic spurious_resp = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        case (a)
            32'h100: mem_data = 32'hAAAA0001;
            32'h204: mem_data = 32'hBBBB0002;
            default: mem_data = {16'hC0DE, a[15:0]};
        endcase
    endfunction

    function automatic vec_t mk(input logic [1:0] v, input logic [1:0] we,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] w0, input logic [31:0] w1,
                                input logic [3:0] b0, input logic [3:0] b1, input logic s1,
                                input logic [31:0] r0, input logic [31:0] r1, input int lat);
        vec_t t;
        t.valid = v;  t.we = we;  t.addr0 = a0; t.addr1 = a1;
        t.wdata0 = w0; t.wdata1 = w1; t.be0 = b0; t.be1 = b1;
        t.skip1 = s1; t.r0 = r0; t.r1 = r1; t.lat = lat;
        return t;
    endfunction

    task automatic drive_pair(input vec_t v, input logic push_req, input logic push_res);
        req_t r;
        res_t e;
        in_valid = v.valid;  in_we = v.we;
        in_addr0 = v.addr0;  in_addr1 = v.addr1;
        in_wdata0 = v.wdata0; in_wdata1 = v.wdata1;
        in_be0 = v.be0;      in_be1 = v.be1;
        if (push_req && v.valid[0]) begin
            r.we = v.we[0]; r.addr = v.addr0; r.wdata = v.wdata0; r.be = v.be0;
            req_q.push_back(r);
        end
        if (push_req && v.valid[1] && !v.skip1) begin
            r.we = v.we[1]; r.addr = v.addr1; r.wdata = v.wdata1; r.be = v.be1;
            req_q.push_back(r);
        end
        if (push_res) begin
            e.sv = v.valid; e.r0 = v.r0; e.r1 = v.r1; e.lat = v.lat;
            res_q.push_back(e);
        end
    endtask

    // Non-valid cycles carry random junk so any late sampling of the inputs shows up.
    task automatic idle_inputs();
        in_valid = 2'b00;        in_we = 2'($urandom);
        in_addr0 = $urandom;     in_addr1 = $urandom;
        in_wdata0 = $urandom;    in_wdata1 = $urandom;
        in_be0 = 4'($urandom);   in_be1 = 4'($urandom);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wait_in_ready", 64'(in_ready), 64'(1));
    endtask

    // Memory model and request scoreboard.
    initial begin
        int   pend;
        logic [31:0] pdata;
        req_t r;
        pend = 0;
        pdata = '0;
        mem_resp_valid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            mem_resp_valid = 1'b0;
            if (!rst_n) pend = 0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_rdata = pdata;
                end
            end else if (spurious_resp) begin
                mem_resp_valid = 1'b1;
                mem_rdata = 32'hBAD0BAD0;
            end
            if (rst_n && mem_req_valid && mem_req_ready) begin
                $display("req  we=%0b addr=%08h wdata=%08h be=%h", mem_we, mem_addr, mem_wdata, mem_be);
                if (req_q.size() == 0) begin
                    chk("unexpected_request", 64'(mem_req_valid), 64'(0));
                end else begin
                    r = req_q.pop_front();
                    chk("req_we", 64'(mem_we), 64'(r.we));
                    chk("req_addr", 64'(mem_addr), 64'(r.addr));
                    chk("req_wdata", 64'(mem_wdata), 64'(r.wdata));
                    chk("req_be", 64'(mem_be), 64'(r.be));
                end
                pend = resp_delay + 1;
                pdata = mem_we ? (32'h5EED0000 | mem_addr) : mem_data(mem_addr);
            end
        end
    end

    // Result scoreboard: compares each out_valid pulse and the hold cycle after it.
    initial begin
        res_t e;
        res_t last;
        logic hold_pending;
        hold_pending = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (hold_pending) begin
                chk("out_valid_one_cycle", 64'(out_valid), 64'(0));
                chk("hold_rdata0", 64'(out_rdata0), 64'(last.r0));
                chk("hold_rdata1", 64'(out_rdata1), 64'(last.r1));
                chk("hold_slot_valid", 64'(out_slot_valid), 64'(last.sv));
                chk("in_ready_after_done", 64'(in_ready), 64'(1));
                hold_pending = 1'b0;
            end
            if (rst_n && in_ready && (|in_valid)) accept_cyc = cyc;
            if (out_valid) begin
                outv_cnt++;
                $display("out  sv=%b r0=%08h r1=%08h lat=%0d", out_slot_valid, out_rdata0, out_rdata1,
                         cyc - accept_cyc);
                if (res_q.size() == 0) begin
                    chk("unexpected_out_valid", 64'(out_valid), 64'(0));
                end else begin
                    e = res_q.pop_front();
                    chk("out_slot_valid", 64'(out_slot_valid), 64'(e.sv));
                    chk("out_rdata0", 64'(out_rdata0), 64'(e.r0));
                    chk("out_rdata1", 64'(out_rdata1), 64'(e.r1));
                    chk("out_latency", 64'(cyc - accept_cyc), 64'(e.lat));
                    last = e;
                    hold_pending = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   saved;
        vec_t v;
        rst_n = 1'b0;
        mem_req_ready = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_stall", 64'(stall), 64'(0));
        chk("rst_mem_req_valid", 64'(mem_req_valid), 64'(0));
        chk("rst_mem_we", 64'(mem_we), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        chk("rst_mem_be", 64'(mem_be), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_slot_valid", 64'(out_slot_valid), 64'(0));
        chk("rst_out_rdata0", 64'(out_rdata0), 64'(0));
        chk("rst_out_rdata1", 64'(out_rdata1), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        vecs[0] = mk(2'b11, 2'b00, 32'h100, 32'h204, 32'h0, 32'h0, 4'hF, 4'hF, 1'b0,
                     32'hAAAA0001, 32'hBBBB0002, 5);
        vecs[1] = mk(2'b10, 2'b10, 32'hFFF0, 32'h40, 32'h1111, 32'h12345678, 4'h1, 4'hF, 1'b0,
                     32'h0, 32'h0, 3);
`ifdef MEM_ARB_FWD_EN
        vecs[2] = mk(2'b11, 2'b01, 32'h80, 32'h80, 32'hDEADBEEF, 32'h0, 4'hF, 4'hF, 1'b1,
                     32'h0, 32'hDEADBEEF, 3);
        vecs[6] = mk(2'b11, 2'b01, 32'h88, 32'h8B, 32'hCAFEF00D, 32'h0, 4'hF, 4'h8, 1'b1,
                     32'h0, 32'hCAFEF00D, 3);
`else
        vecs[2] = mk(2'b11, 2'b01, 32'h80, 32'h80, 32'hDEADBEEF, 32'h0, 4'hF, 4'hF, 1'b0,
                     32'h0, 32'hC0DE0080, 5);
        vecs[6] = mk(2'b11, 2'b01, 32'h88, 32'h8B, 32'hCAFEF00D, 32'h0, 4'hF, 4'h8, 1'b0,
                     32'h0, 32'hC0DE008B, 5);
`endif
        vecs[3] = mk(2'b01, 2'b00, 32'h300, 32'h999, 32'h0, 32'h0, 4'hF, 4'hF, 1'b0,
                     32'hC0DE0300, 32'h0, 3);
        vecs[4] = mk(2'b11, 2'b11, 32'h10, 32'h14, 32'h01020304, 32'h05060708, 4'hF, 4'h3, 1'b0,
                     32'h0, 32'h0, 5);
        vecs[5] = mk(2'b11, 2'b01, 32'h84, 32'h84, 32'h77777777, 32'h0, 4'h3, 4'hF, 1'b0,
                     32'h0, 32'hC0DE0084, 5);
        vecs[7] = mk(2'b11, 2'b10, 32'h200, 32'h204, 32'h0, 32'h55AA55AA, 4'hF, 4'hF, 1'b0,
                     32'hC0DE0200, 32'h0, 5);

        // Each pair is presented on the first cycle in_ready is back: back-to-back operation.
        for (int i = 0; i < 8; i++) begin
            wait_ready();
            drive_pair(vecs[i], 1'b1, 1'b1);
            @(negedge clk);
            idle_inputs();
            chk("stall_after_accept", 64'(stall), 64'(1));
        end

        wait_ready();
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            @(negedge clk);
            chk("no_valid_in_ready", 64'(in_ready), 64'(1));
            chk("no_valid_no_req", 64'(mem_req_valid), 64'(0));
        end

        // Backpressure in ISSUE0 with a spurious response on the first stalled cycle.
        wait_ready();
        mem_req_ready = 1'b0;
        v = vecs[0];
        v.lat = 8;
        drive_pair(v, 1'b1, 1'b1);
        @(negedge clk);
        idle_inputs();
        spurious_resp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_req_valid", 64'(mem_req_valid), 64'(1));
            chk("bp_addr", 64'(mem_addr), 64'(32'h100));
            chk("bp_we", 64'(mem_we), 64'(0));
            chk("bp_stall", 64'(stall), 64'(1));
            @(negedge clk);
            spurious_resp = 1'b0;
        end
        mem_req_ready = 1'b1;

        // Reset while WAIT1 is outstanding: pair discarded, no out_valid.
        wait_ready();
        resp_delay = 3;
        drive_pair(vecs[0], 1'b1, 1'b0);
        @(negedge clk);
        idle_inputs();
        n = 0;
        while (!(mem_req_valid && mem_addr == 32'h204) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_issue1", 64'(mem_addr), 64'(32'h204));
        @(negedge clk);
        saved = outv_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_wait1_in_ready", 64'(in_ready), 64'(1));
        chk("rst_wait1_stall", 64'(stall), 64'(0));
        chk("rst_wait1_req_valid", 64'(mem_req_valid), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        resp_delay = 0;
        repeat (8) @(negedge clk);
        chk("no_out_after_reset", 64'(outv_cnt), 64'(saved));

        // Reset while a request is stalled in ISSUE0: mem_req_valid must drop at once.
        wait_ready();
        mem_req_ready = 1'b0;
        drive_pair(vecs[7], 1'b0, 1'b0);
        @(negedge clk);
        idle_inputs();
        chk("rst_issue_req_valid_before", 64'(mem_req_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_issue_req_valid_after", 64'(mem_req_valid), 64'(0));
        chk("rst_issue_addr_after", 64'(mem_addr), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mem_req_ready = 1'b1;

        wait_ready();
        drive_pair(vecs[0], 1'b1, 1'b1);
        @(negedge clk);
        idle_inputs();

        n = 0;
        while ((res_q.size() != 0 || !in_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("results_drained", 64'(res_q.size()), 64'(0));
        chk("requests_drained", 64'(req_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences the two memory requests produced per cycle by the dual-issue execute stage (FU0, FU1) onto the single data-memory port. It buffers an issued pair, presents slot 0 then slot 1 to memory one at a time, collects responses, and returns both results to writeback together. The block stalls the issue pipeline while a pair is in flight.

## Interface
- ADDR_W, 32, request address width
- DATA_W, 32, data width; byte enables are DATA_W/8 bits

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  2  per-slot request valid; bit 0 = FU0, bit 1 = FU1
- in_we  in  2  per-slot store (1) / load (0)
- in_addr0, in_addr1  in  ADDR_W  per-slot byte address
- in_wdata0, in_wdata1  in  DATA_W  per-slot store data
- in_be0, in_be1  in  DATA_W/8  per-slot byte enables
- in_ready  out  1  pair accepted when in_ready && |in_valid
- stall  out  1  equals ~in_ready; drives pipeline hold
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_W/DATA_W/DATA_W/8  request fields
- mem_resp_valid  in  1  response for the single outstanding request (load data or store ack)
- mem_rdata  in  DATA_W  load data
- out_valid  out  1  one-cycle pulse: pair complete
- out_slot_valid  out  2  which slots were serviced
- out_rdata0, out_rdata1  out  DATA_W  raw word per slot (0 for stores)

## Operation
- FSM states: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, DONE.
- IDLE: in_ready=1. On accept, latch all slot fields and in_valid into internal buffers. Next state: ISSUE0 if in_valid[0], else ISSUE1.
- ISSUEn: mem_req_valid=1 with slot n fields; fields are stable until mem_req_ready. On handshake -> WAITn.
- WAITn: on mem_resp_valid, capture mem_rdata into slot n result (loads; stores keep 0). WAIT0 -> ISSUE1 if slot 1 is valid, else DONE. WAIT1 -> DONE.
- DONE: out_valid=1 for exactly one cycle with out_slot_valid = latched in_valid. Results and out_slot_valid hold until the next DONE. Next state: IDLE.
- Only one outstanding memory request at any time. Slot 0 always completes before slot 1 is issued (program order).
- mem_resp_valid outside WAIT0/WAIT1 is ignored. No state change, no data capture.
- in_valid==2'b00 while in IDLE: nothing is accepted; stays in IDLE.
- Writeback has no backpressure on out_*.

## Timing
- Reset values: state IDLE; in_ready=1; stall=0; mem_req_valid=0; mem_we=0; mem_addr/mem_wdata/mem_be=0; out_valid=0; out_slot_valid=0; out_rdata0/1=0; all buffers 0.
- Reset asserted mid-operation: FSM returns to IDLE asynchronously, mem_req_valid drops immediately, the in-flight pair is discarded, and no out_valid is produced.
- Accept at cycle T. mem_req_valid is first asserted at T+1.
- A memory response arrives no earlier than the cycle after its request handshake.
- Zero-wait memory (ready=1, response in the next cycle):
  - Pair: issue T+1, response T+2, issue T+3, response T+4, out_valid T+5, in_ready T+6.
  - Single slot: out_valid T+3.
- stall is combinational from state only, not from inputs.

## Configuration
- MEM_ARB_FWD_EN defined: store-to-load forwarding applies when all of the following hold:
  - both slots are valid;
  - slot 0 is a store and slot 1 is a load;
  - in_addr0[ADDR_W-1:2]==in_addr1[ADDR_W-1:2];
  - in_be0 is all ones.
- When forwarding applies: WAIT0 goes straight to DONE, out_rdata1 = latched in_wdata0, and no memory request is issued for slot 1. Pair latency with zero-wait memory is out_valid at T+3.
- MEM_ARB_FWD_EN undefined: no compare logic is built, and slot 1 is always issued to memory.

## Test plan
- Reset: hold rst_n=0 -> in_ready=1, all other outputs 0. Pulse rst_n low during WAIT1 -> mem_req_valid=0 immediately, FSM in IDLE, no out_valid.
- Load pair, zero-wait memory: slot0 load 0x100 returns 0xAAAA0001, slot1 load 0x204 returns 0xBBBB0002 -> requests in order 0x100 then 0x204, out_valid at T+5, out_rdata0=0xAAAA0001, out_rdata1=0xBBBB0002, out_slot_valid=2'b11.
- Single slot 1 store to 0x40, wdata 0x12345678, be 4'hF -> one request with mem_we=1, out_valid at T+3, out_slot_valid=2'b10, out_rdata1=0.
- Backpressure: mem_req_ready low for 3 cycles in ISSUE0 -> request fields stable, stall=1 throughout, pair completes 3 cycles late; a spurious mem_resp_valid during ISSUE0 is ignored.
- Slot0 store 0x80 with 0xDEADBEEF and be 4'hF, slot1 load 0x80:
  - with MEM_ARB_FWD_EN: one memory request, out_rdata1=0xDEADBEEF, out_valid at T+3;
  - without MEM_ARB_FWD_EN: two requests, out_rdata1 = memory data.
- Back-to-back pairs: present a new pair on the cycle in_ready returns -> accepted immediately, no request lost, ordering preserved across pairs.
